// File: rtl/retospect_clockbox_mc.sv
// Multi-channel tick generator driving the CNB clockbus; first element of the config chain.
// Optional per-channel start phase is enabled with RETOSPECT_CLKBOX_PHASE_EN.
module retospect_clockbox_mc #(
    parameter int unsigned N_CH  = 6,
    parameter int unsigned CNT_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            reset_nn,
    input  logic            config_en,
    input  logic            bs_in,
    output logic            bs_out,
    output logic [N_CH+1:0] clockbus
);

`ifdef RETOSPECT_CLKBOX_PHASE_EN
    localparam int unsigned WordW = 2 * CNT_W + 1;
`else
    localparam int unsigned WordW = CNT_W + 1;
`endif

    logic [WordW-1:0] cfg_q [N_CH];
    logic [WordW-1:0] cfg_d [N_CH];
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [CNT_W-1:0] max_w [N_CH];
    logic [CNT_W-1:0] load_w [N_CH];
    logic [N_CH-1:0]  mode_w;
    logic [N_CH-1:0]  match_w;
    logic [N_CH-1:0]  out_q;
    logic [N_CH-1:0]  out_d;

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            max_w[i]   = cfg_q[i][CNT_W-1:0];
            mode_w[i]  = cfg_q[i][CNT_W];
`ifdef RETOSPECT_CLKBOX_PHASE_EN
            load_w[i]  = cfg_q[i][WordW-1:CNT_W+1];
`else
            load_w[i]  = '0;
`endif
            // >= lets a count stranded above a freshly loaded max wrap immediately
            match_w[i] = (cnt_q[i] >= max_w[i]);
        end
    end

    always_comb begin
        cfg_d = cfg_q;
        cnt_d = cnt_q;
        out_d = out_q;
        if (reset_nn) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_d[i] = load_w[i];
            end
            out_d = '0;
        end else if (config_en) begin
            cfg_d[0] = {bs_in, cfg_q[0][WordW-1:1]};
            for (int i = 1; i < N_CH; i++) begin
                cfg_d[i] = {cfg_q[i-1][0], cfg_q[i][WordW-1:1]};
            end
            // square channels keep their level while the chain shifts
            for (int i = 0; i < N_CH; i++) begin
                if (!mode_w[i]) begin
                    out_d[i] = 1'b0;
                end
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_d[i] = match_w[i] ? '0 : cnt_q[i] + CNT_W'(1);
                out_d[i] = mode_w[i] ? (out_q[i] ^ match_w[i]) : match_w[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                cfg_q[i] <= '0;
                cnt_q[i] <= '0;
            end
            out_q <= '0;
        end else begin
            cfg_q <= cfg_d;
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign bs_out   = cfg_q[N_CH-1][0];
    assign clockbus = {out_q, 2'b10};

endmodule

// File: tb/tb_retospect_clockbox_mc.sv
// Scoreboard bench for retospect_clockbox_mc: stimulus queues expected bus/bs_out per cycle,
// a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_retospect_clockbox_mc;
    localparam int unsigned N_CH  = 6;
    localparam int unsigned CNT_W = 8;
`ifdef RETOSPECT_CLKBOX_PHASE_EN
    localparam int unsigned WW = 2 * CNT_W + 1;
`else
    localparam int unsigned WW = CNT_W + 1;
`endif
    localparam int unsigned L  = N_CH * WW;
    localparam int unsigned BW = N_CH + 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          reset_nn = 1'b0;
    logic          config_en = 1'b1;
    logic          bs_in = 1'b1;
    logic          bs_out;
    logic [BW-1:0] clockbus;

    always #5 clk = ~clk;

    retospect_clockbox_mc #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .reset_nn (reset_nn),
        .config_en(config_en),
        .bs_in    (bs_in),
        .bs_out   (bs_out),
        .clockbus (clockbus)
    );

    typedef struct {
        string         name;
        int            cyc;
        logic [BW-1:0] bus;
        logic [BW-1:0] mask;
        logic          bs;
        bit            chk_bs;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [WW-1:0]  words [N_CH];
    logic [127:0]   pat_src;
    logic [L-1:0]   pat_p;
    logic [L-1:0]   pat_q;
    logic [BW-1:0]  eb;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: compares every entry queued for the cycle just completed
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_cmp++;
                if ((clockbus & e.mask) !== (e.bus & e.mask)) begin
                    n_err++;
                    $display("FAIL %s cyc=%0d clockbus=%b expected=%b mask=%b",
                             e.name, e.cyc, clockbus, e.bus, e.mask);
                end
                if (e.chk_bs) begin
                    n_cmp++;
                    if (bs_out !== e.bs) begin
                        n_err++;
                        $display("FAIL %s_bs cyc=%0d bs_out=%b expected=%b",
                                 e.name, e.cyc, bs_out, e.bs);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, %0d entries pending", sb.size());
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [BW-1:0] bus,
                              input logic [BW-1:0] mask, input logic bs, input bit chk_bs);
        exp_t e;
        e.name   = name;
        e.cyc    = cyc;
        e.bus    = bus;
        e.mask   = mask;
        e.bs     = bs;
        e.chk_bs = chk_bs;
        sb.push_back(e);
    endtask

    function automatic logic [WW-1:0] mk(input logic mode, input logic [CNT_W-1:0] max);
        logic [WW-1:0] w;
        w = '0;
        w[CNT_W-1:0] = max;
        w[CNT_W]     = mode;
        return w;
    endfunction

    // Shift words[] into the chain; first/rest masks of zero skip checking
    task automatic load_words(input logic [BW-1:0] first_bus, input logic [BW-1:0] first_mask,
                              input logic [BW-1:0] rest_bus, input logic [BW-1:0] rest_mask);
        logic [L-1:0] img;
        for (int i = 0; i < N_CH; i++) begin
            img[(N_CH-1-i)*WW +: WW] = words[i];
        end
        config_en = 1'b1;
        for (int k = 0; k < L; k++) begin
            bs_in = img[k];
            tick();
            if (k == 0 && first_mask != '0) expect_out("cfg_first", first_bus, first_mask, 1'b0, 0);
            if (k != 0 && rest_mask != '0) expect_out("cfg_hold", rest_bus, rest_mask, 1'b0, 0);
        end
        config_en = 1'b0;
        bs_in     = 1'b0;
    endtask

    task automatic pulse_nn();
        reset_nn = 1'b1;
        tick();
        expect_out("nn", BW'(2), '1, 1'b0, 0);
        reset_nn = 1'b0;
    endtask

    initial begin
        // Reset dominates config_en and bs_in
        tick();
        expect_out("reset1", BW'(2), '1, 1'b0, 1);
        tick();
        expect_out("reset2", BW'(2), '1, 1'b0, 1);
        reset     = 1'b0;
        config_en = 1'b0;
        bs_in     = 1'b0;

        // Chain: load pattern, then push a second one and watch the first emerge
        pat_src = 128'h2D5A_5C3F_09E1_BD76_C3A1_0F5E_9B24_E817;
        pat_p   = pat_src[L-1:0];
        pat_q   = ~pat_p;
        config_en = 1'b1;
        for (int k = 0; k < L; k++) begin
            bs_in = pat_p[k];
            tick();
        end
        for (int k = 0; k < L; k++) begin
            expect_out("chain", BW'(2), '1, pat_p[k], 1);
            bs_in = pat_q[k];
            tick();
        end
        config_en = 1'b0;
        bs_in     = 1'b0;

        // Pulse/square/edge-value run
        words[0] = mk(1'b0, 8'd3);
        words[1] = mk(1'b1, 8'd0);
        words[2] = mk(1'b0, 8'hFF);
        for (int i = 3; i < N_CH; i++) words[i] = mk(1'b1, 8'hFF);
        load_words(BW'(2), '1, BW'(2), '1);
        pulse_nn();
        for (int e = 1; e <= 260; e++) begin
            tick();
            eb    = BW'(2);
            eb[2] = (e % 4 == 0);
            eb[3] = (e % 2 == 1);
            eb[4] = (e == 256);
            for (int i = 3; i < N_CH; i++) eb[2+i] = (e >= 256);
            expect_out("run", eb, '1, 1'b0, 0);
        end

        // Mid-run reconfiguration with a count stranded above the new max
        words[0] = mk(1'b0, 8'd9);
        words[1] = mk(1'b0, 8'd0);
        words[2] = mk(1'b1, 8'd0);
        for (int i = 3; i < N_CH; i++) words[i] = mk(1'b0, 8'hFF);
        load_words('0, '0, '0, '0);
        pulse_nn();
        for (int e = 1; e <= 7; e++) begin
            tick();
            eb    = BW'(2);
            eb[3] = 1'b1;
            eb[4] = (e % 2 == 1);
            expect_out("pre_cfg", eb, '1, 1'b0, 0);
        end
        for (int i = 0; i < N_CH; i++) words[i] = mk(1'b0, 8'hFF);
        words[0] = mk(1'b0, 8'd2);
        load_words(BW'('h12), '1, BW'(2), BW'(7));
        for (int e = 1; e <= 7; e++) begin
            tick();
            eb    = BW'(2);
            eb[2] = (e % 3 == 1);
            expect_out("post_cfg", eb, '1, 1'b0, 0);
        end

`ifdef RETOSPECT_CLKBOX_PHASE_EN
        // Staggered channels: same period, ch1 starts at phase 2
        for (int i = 0; i < N_CH; i++) words[i] = mk(1'b0, 8'hFF);
        words[0] = {8'd0, 1'b0, 8'd3};
        words[1] = {8'd2, 1'b0, 8'd3};
        load_words('0, '0, '0, '0);
        pulse_nn();
        for (int e = 1; e <= 12; e++) begin
            tick();
            eb    = BW'(2);
            eb[2] = (e % 4 == 0);
            eb[3] = (e % 4 == 2);
            expect_out("phase", eb, '1, 1'b0, 0);
        end
`endif

        tick();
        tick();
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
